// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the per-stage FFT pipeline controllers:
// state encoding and the size helpers used to derive counter/address widths.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fft_state_e;

    function automatic int max1(input int w);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int log2n(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int half_blk(input int nfft, input int stage);
        return nfft >> stage;
    endfunction

    // Twiddle ROM address width; a degenerate 2-point FFT still gets one bit.
    function automatic int tw_addr_w(input int nfft);
        return max1(log2n(nfft) - 1);
    endfunction

endpackage

// File: rtl/sdf_beat_counter.sv
// Enabled up-counter that wraps MAXV -> 0, with synchronous clear and a
// terminal-count flag decoded from the current value.
module sdf_beat_counter #(
    parameter int WIDTH = 3,
    parameter int MAXV  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == WIDTH'(MAXV));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sdf_stage_seq_ctrl.sv
// Per-stage sequencer for a radix-2 DIF SDF FFT: butterfly mux select, twiddle
// ROM address/enable and output-valid for one stage, with stall, multi-frame and flush.
//
//  state | meaning
//  IDLE  | waiting for start; no samples accepted
//  RUN   | accepting beats; sel follows the half-block bit of the beat counter
//  FLUSH | D cycles draining the delay line through the twiddle multiplier
module sdf_stage_seq_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int NFFT     = 128,
    parameter int STAGE_NO = 1,
    parameter int FRM_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [FRM_W-1:0]              i_num_frames,
    input  logic                          i_stop,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    output logic                          o_sel,
    output logic                          o_tw_en,
    output logic [tw_addr_w(NFFT)-1:0]    o_tw_addr,
    output logic                          o_out_valid,
    output logic                          o_frame_done,
    output logic                          o_busy,
    output logic                          o_run_done
);

    localparam int LOG2N = log2n(NFFT);
    localparam int D     = half_blk(NFFT, STAGE_NO);
    localparam int JW    = max1(LOG2N - STAGE_NO);
    localparam int TW_W  = tw_addr_w(NFFT);
    localparam int H_BIT = LOG2N - STAGE_NO;

    fft_state_e         r_state;
    fft_state_e         w_state_nxt;

    logic [LOG2N-1:0]   w_k;
    logic               w_k_tc;
    logic               w_k_en;
    logic               w_k_clr;
    logic [JW-1:0]      w_fl;
    logic               w_fl_tc;
    logic               w_fl_en;

    logic [JW-1:0]      w_j;
    logic               w_h;
    logic [TW_W-1:0]    w_tw_run;
    logic [TW_W-1:0]    w_tw_fl;

    logic               w_load;
    logic               w_frm_inc;
    logic               w_prime_set;
    logic               w_end;
    logic [FRM_W-1:0]   w_frm_nxt;

    logic [FRM_W-1:0]   r_num_frames;
    logic [FRM_W-1:0]   r_frm_cnt;
    logic               r_stop;
    logic               r_prime;

    sdf_beat_counter #(
        .WIDTH (LOG2N),
        .MAXV  (NFFT - 1)
    ) u_k_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_k_clr),
        .i_en  (w_k_en),
        .o_cnt (w_k),
        .o_tc  (w_k_tc)
    );

    sdf_beat_counter #(
        .WIDTH (JW),
        .MAXV  (D - 1)
    ) u_fl_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_load),
        .i_en  (w_fl_en),
        .o_cnt (w_fl),
        .o_tc  (w_fl_tc)
    );

    // j is k mod D; the mask is zero when D=1 so j collapses to 0.
    assign w_j      = JW'(w_k & LOG2N'(D - 1));
    assign w_h      = w_k[H_BIT];
    assign w_tw_run = TW_W'(w_j) << (STAGE_NO - 1);
    assign w_tw_fl  = TW_W'(w_fl) << (STAGE_NO - 1);

    // Frame count saturates so a continuous run never aliases onto num_frames.
    assign w_frm_nxt = (&r_frm_cnt) ? r_frm_cnt : r_frm_cnt + 1'b1;
    assign w_end     = ((r_num_frames != '0) && (w_frm_nxt == r_num_frames))
                       || r_stop || i_stop;

    assign o_busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_in_ready   = 1'b0;
        o_sel        = 1'b0;
        o_out_valid  = 1'b0;
        o_tw_en      = 1'b0;
        o_tw_addr    = '0;
        o_frame_done = 1'b0;
        o_run_done   = 1'b0;
        w_k_en       = 1'b0;
        w_k_clr      = 1'b0;
        w_fl_en      = 1'b0;
        w_load       = 1'b0;
        w_frm_inc    = 1'b0;
        w_prime_set  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                    w_k_clr     = 1'b1;
                end
            end

            ST_RUN: begin
                o_in_ready = 1'b1;
                o_sel      = w_h;
                if (i_in_valid) begin
                    w_k_en      = 1'b1;
                    o_tw_en     = r_prime & ~w_h;
                    o_out_valid = o_tw_en | w_h;
                    if (o_tw_en) begin
                        o_tw_addr = w_tw_run;
                    end
                    // Delay line holds valid data once the first half-block is in.
                    if (w_j == JW'(D - 1)) begin
                        w_prime_set = 1'b1;
                    end
                    if (w_k_tc) begin
                        o_frame_done = 1'b1;
                        w_frm_inc    = 1'b1;
                        if (w_end) begin
                            w_state_nxt = ST_FLUSH;
                        end
                    end
                end
            end

            ST_FLUSH: begin
                o_out_valid = 1'b1;
                o_tw_en     = 1'b1;
                o_tw_addr   = w_tw_fl;
                w_fl_en     = 1'b1;
                if (w_fl_tc) begin
                    o_run_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num_frames <= '0;
            r_frm_cnt    <= '0;
            r_stop       <= 1'b0;
            r_prime      <= 1'b0;
        end else if (w_load) begin
            r_num_frames <= i_num_frames;
            r_frm_cnt    <= '0;
            r_stop       <= 1'b0;
            r_prime      <= 1'b0;
        end else begin
            if (w_frm_inc) begin
                r_frm_cnt <= w_frm_nxt;
            end
            if ((r_state == ST_RUN) && i_stop) begin
                r_stop <= 1'b1;
            end
            if (w_prime_set) begin
                r_prime <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdf_stage_seq_ctrl.sv
// Bench for sdf_stage_seq_ctrl: three NFFT=8 stages (D=4,2,1) share stimulus and are
// compared every cycle against an arithmetic model of beat index -> k, h, j, prime.
module tb_sdf_stage_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_in_valid = 1'b0;
    logic [15:0] i_num_frames = '0;

    logic [2:0]      a_rdy, a_sel, a_twen, a_ov, a_fd, a_busy, a_rd;
    logic [2:0][1:0] a_tw;

    int n_checks = 0;
    int n_errors = 0;
    int ov_cnt[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sdf_stage_seq_ctrl #(
            .NFFT     (8),
            .STAGE_NO (g + 1),
            .FRM_W    (16)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .i_start      (i_start),
            .i_num_frames (i_num_frames),
            .i_stop       (i_stop),
            .i_in_valid   (i_in_valid),
            .o_in_ready   (a_rdy[g]),
            .o_sel        (a_sel[g]),
            .o_tw_en      (a_twen[g]),
            .o_tw_addr    (a_tw[g]),
            .o_out_valid  (a_ov[g]),
            .o_frame_done (a_fd[g]),
            .o_busy       (a_busy[g]),
            .o_run_done   (a_rd[g])
        );
    end

    // {in_ready, sel, out_valid, tw_en, tw_addr[1:0], frame_done, busy, run_done}
    function automatic logic [8:0] got_vec(input int g);
        return {a_rdy[g], a_sel[g], a_ov[g], a_twen[g], a_tw[g], a_fd[g], a_busy[g], a_rd[g]};
    endfunction

    task automatic run_frames(input string name, input int nf, input int pv,
                              input int stop_beat, input int restart_beat);
        int b, frames, k, h, j, d;
        bit v, prime, stop_seen, done, e_twen, e_ov, e_fd;
        logic [1:0] e_tw;
        logic [8:0] exp_v;

        @(negedge clk);
        i_start = 1'b1;
        i_num_frames = nf[15:0];
        i_in_valid = 1'b0;
        i_stop = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (got_vec(g) !== 9'b0) begin
                n_errors++;
                $display("FAIL %s_start inst%0d got=%b exp=%b", name, g, got_vec(g), 9'b0);
            end
            ov_cnt[g] = 0;
        end
        @(negedge clk);
        i_start = 1'b0;

        b = 0;
        frames = 0;
        stop_seen = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            v = ($urandom_range(99) < pv);
            i_in_valid = v;
            i_stop = (stop_beat >= 0) && (b == stop_beat) && !stop_seen;
            if (i_stop) stop_seen = 1'b1;
            i_start = (b == restart_beat);
            i_num_frames = i_start ? 16'd5 : nf[15:0];
            #1;
            k = b % 8;
            for (int g = 0; g < 3; g++) begin
                d = 4 >> g;
                h = (k / d) % 2;
                j = k % d;
                prime = (b >= d);
                e_twen = v && prime && (h == 0);
                e_ov = v && ((h == 1) || prime);
                e_tw = e_twen ? 2'(j << g) : 2'd0;
                e_fd = v && (k == 7);
                exp_v = {1'b1, h[0], e_ov, e_twen, e_tw, e_fd, 1'b1, 1'b0};
                n_checks++;
                if (got_vec(g) !== exp_v) begin
                    n_errors++;
                    $display("FAIL %s_run inst%0d beat%0d got=%b exp=%b", name, g, b, got_vec(g), exp_v);
                end
                ov_cnt[g] += int'(a_ov[g]);
            end
            if (v) begin
                b++;
                if (k == 7) begin
                    frames++;
                    if ((nf != 0 && frames == nf) || stop_seen) done = 1'b1;
                end
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        i_stop = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s_timeout got=%0d frames exp=%0d", name, frames, nf);
        end

        // Flush: stop and in_valid are toggled randomly and must have no effect.
        for (int c = 0; c < 4; c++) begin
            i_in_valid = 1'($urandom_range(1));
            i_stop = 1'($urandom_range(1));
            #1;
            for (int g = 0; g < 3; g++) begin
                d = 4 >> g;
                if (c < d) begin
                    e_tw = 2'(c << g);
                    exp_v = {1'b0, 1'b0, 1'b1, 1'b1, e_tw, 1'b0, 1'b1, (c == d - 1)};
                end else begin
                    exp_v = 9'b0;
                end
                n_checks++;
                if (got_vec(g) !== exp_v) begin
                    n_errors++;
                    $display("FAIL %s_flush inst%0d cyc%0d got=%b exp=%b", name, g, c, got_vec(g), exp_v);
                end
                ov_cnt[g] += int'(a_ov[g]);
            end
            @(negedge clk);
        end
        i_stop = 1'b0;
        i_in_valid = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (got_vec(g) !== 9'b0) begin
                n_errors++;
                $display("FAIL %s_idle inst%0d got=%b exp=%b", name, g, got_vec(g), 9'b0);
            end
            n_checks++;
            if (ov_cnt[g] !== frames * 8) begin
                n_errors++;
                $display("FAIL %s_ovtotal inst%0d got=%0d exp=%0d", name, g, ov_cnt[g], frames * 8);
            end
        end
    endtask

    task automatic test_reset();
        i_in_valid = 1'b1;
        i_stop = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (got_vec(g) !== 9'b0) begin
                n_errors++;
                $display("FAIL reset inst%0d got=%b exp=%b", g, got_vec(g), 9'b0);
            end
        end
        i_in_valid = 1'b0;
        i_stop = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_frame();
        run_frames("single", 1, 100, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_frames("b2b", 2, 100, -1, -1);
    endtask

    task automatic test_random_valid();
        run_frames("rand_valid", 3, 50, -1, 10);
    endtask

    task automatic test_stop_continuous();
        run_frames("stop_mid", 0, 100, 19, -1);
    endtask

    task automatic test_stop_final_frame();
        run_frames("stop_final", 2, 70, 15, -1);
    endtask

    task automatic test_stop_idle();
        @(negedge clk);
        i_stop = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (a_busy[g] !== 1'b0) begin
                n_errors++;
                $display("FAIL stop_idle inst%0d got=%b exp=0", g, a_busy[g]);
            end
        end
        @(negedge clk);
        i_stop = 1'b0;
        run_frames("after_idle_stop", 2, 100, -1, -1);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        i_start = 1'b1;
        i_num_frames = 16'd1;
        @(negedge clk);
        i_start = 1'b0;
        i_in_valid = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (got_vec(g) !== 9'b0) begin
                n_errors++;
                $display("FAIL mid_reset inst%0d got=%b exp=%b", g, got_vec(g), 9'b0);
            end
        end
        @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (got_vec(g) !== 9'b0) begin
                n_errors++;
                $display("FAIL mid_reset_hold inst%0d got=%b exp=%b", g, got_vec(g), 9'b0);
            end
        end
        i_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_frames("post_reset", 1, 100, -1, -1);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random_valid();
        test_stop_continuous();
        test_stop_final_frame();
        test_stop_idle();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
